dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_select.sv | 53 +++++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// requester index constants.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN (round-robin tie break).
package dmem_arb_pkg;

  // Transaction FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Requester indices
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_SEC  = 1'b1;

  // The requester that is not `idx`
  function automatic logic other_req(input logic idx);
    return (idx == REQ_CORE) ? REQ_SEC : REQ_CORE;
  endfunction

endpackage

// File: rtl/dmem_arb_select.sv
// Winner selection between the core (0) and secondary (1) requesters.
// Default build: fixed priority, requester 0 wins ties, purely combinational.
// With DMEM_ARB_ROUND_ROBIN_EN defined: ties go to the requester not granted
// last; a one-bit pointer records the last winner and resets to favour
// requester 0.
module dmem_arb_select
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  input  logic clock,
  input  logic reset,
  input  logic take_i,
`endif
  input  logic req0_i,
  input  logic req1_i,
  output logic any_o,
  output logic win_o
);

  assign any_o = req0_i | req1_i;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  // Record the requester that actually received a grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= REQ_SEC;
    end else if (take_i) begin
      last_q <= win_o;
    end
  end

  // Tie goes to the requester not granted last
  always_comb begin
    win_o = REQ_CORE;
    if (req0_i && req1_i) begin
      win_o = other_req(last_q);
    end else if (req1_i) begin
      win_o = REQ_SEC;
    end
  end
`else
  // Fixed priority: requester 0 always wins a tie
  always_comb begin
    win_o = REQ_CORE;
    if (!req0_i && req1_i) begin
      win_o = REQ_SEC;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter. One transaction at a time:
// IDLE (grant + capture) -> ISSUE (one-cycle strobe) -> WAIT (until mem_valid).
// gnt*/done*/rdata are decoded in the cycle they refer to so that a grant,
// the strobe one cycle later and the completion all meet minimum latency.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN (see dmem_arb_select).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    wr0,
  input  logic                    wr1,
  input  logic [ADDRESS_BITS-1:0] addr0,
  input  logic [ADDRESS_BITS-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]   wdata0,
  input  logic [DATA_WIDTH-1:0]   wdata1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    done0,
  output logic                    done1,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_in_data,
  input  logic [DATA_WIDTH-1:0]   mem_out_data,
  input  logic                    mem_valid,
  input  logic                    mem_ready
);

  arb_state_e              state_q;
  logic                    owner_q;
  logic                    wr_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    mem_read_q;
  logic                    mem_write_q;

  logic                    any_req;
  logic                    win;
  logic                    take_d;
  logic                    resp_d;
  logic                    win_wr;
  logic [ADDRESS_BITS-1:0] win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;

  dmem_arb_select u_select (
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    .clock  (clock),
    .reset  (reset),
    .take_i (take_d),
`endif
    .req0_i (req0),
    .req1_i (req1),
    .any_o  (any_req),
    .win_o  (win)
  );

  // A command is captured only from IDLE, with downstream ready and no stall
  assign take_d = (state_q == IDLE) && any_req && mem_ready && !stall;

  // A response is only meaningful while waiting for one
  assign resp_d = (state_q == WAIT) && mem_valid;

  // Route the winner's command payload to the capture registers
  always_comb begin
    win_wr    = wr0;
    win_addr  = addr0;
    win_wdata = wdata0;
    if (win == REQ_SEC) begin
      win_wr    = wr1;
      win_addr  = addr1;
      win_wdata = wdata1;
    end
  end

  // Transaction FSM with captured command and registered downstream strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= REQ_CORE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (take_d) begin
            owner_q     <= win;
            wr_q        <= win_wr;
            addr_q      <= win_addr;
            wdata_q     <= win_wdata;
            mem_read_q  <= !win_wr;
            mem_write_q <= win_wr;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (mem_valid) begin
            state_q <= IDLE;
          end
        end
        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Grant is gated by reset so nothing is granted while reset is held in IDLE
  assign gnt0 = take_d && !reset && (win == REQ_CORE);
  assign gnt1 = take_d && !reset && (win == REQ_SEC);

  assign done0 = resp_d && (owner_q == REQ_CORE);
  assign done1 = resp_d && (owner_q == REQ_SEC);
  assign rdata = (resp_d && !wr_q) ? mem_out_data : '0;

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = addr_q;
  assign mem_in_data = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// transactions against a transaction-level expectation model.
module tb_dmem_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in_data;
  logic [DW-1:0] mem_out_data;
  logic          mem_valid, mem_ready;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          last_win;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_in_data(mem_in_data),
    .mem_out_data(mem_out_data), .mem_valid(mem_valid), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected winner from the arbitration rules
  function automatic bit pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      return !last_win;
`else
      return 1'b0;
`endif
    end
    return (r1 && !r0);
  endfunction

  // One full transaction from grant to done; lat = cycles from strobe to mem_valid
  task automatic do_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input int unsigned lat, input logic [DW-1:0] rd,
                        input bit noise);
    bit            win, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    win = pick(r0, r1);
    last_win = win;
    w = win ? w1 : w0;
    a = win ? a1 : a0;
    d = win ? d1 : d0;
    // cycle 0: grant
    step();
    req0 = r0; req1 = r1; wr0 = w0; wr1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    stall = 1'b0; mem_ready = 1'b1;
    mem_valid = noise ? 1'($urandom) : 1'b0;
    mem_out_data = $urandom;
    #3;
    chk("gnt0", gnt0, !win);
    chk("gnt1", gnt1, win);
    chk("idle_done", {done0, done1}, 2'b00);
    chk("idle_strobe", {mem_read, mem_write}, 2'b00);
    // cycle 1: strobe
    step();
    if (win) req1 = 1'b0; else req0 = 1'b0;
    mem_valid = noise ? 1'($urandom) : 1'b0;
    stall = noise ? 1'($urandom) : 1'b0;
    #3;
    chk("strobe", {mem_read, mem_write}, {!w, w});
    chk("mem_address", mem_address, a);
    if (w) chk("mem_in_data", mem_in_data, d);
    chk("issue_gnt", {gnt0, gnt1}, 2'b00);
    chk("issue_done", {done0, done1}, 2'b00);
    // waiting cycles
    for (int unsigned k = 2; k <= lat; k++) begin
      step();
      mem_valid = 1'b0;
      stall = noise ? 1'($urandom) : 1'b0;
      #3;
      chk("wait_quiet", {mem_read, mem_write, done0, done1, gnt0, gnt1}, 6'd0);
    end
    // response
    step();
    mem_valid = 1'b1;
    mem_out_data = rd;
    #3;
    chk("done", {done0, done1}, {!win, win});
    chk("rdata", rdata, w ? '0 : rd);
    chk("done_gnt", {gnt0, gnt1}, 2'b00);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; req0 = 1'b0; req1 = 1'b0;
    wr0 = 1'b0; wr1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_out_data = '0; mem_valid = 1'b0; mem_ready = 1'b1;
    last_win = 1'b1;
    #3;
    chk("rst_outputs", {gnt0, gnt1, done0, done1, mem_read, mem_write}, 6'd0);
    chk("rst_addr", mem_address, '0);
    chk("rst_wdata", mem_in_data, '0);
    chk("rst_rdata", rdata, '0);
    step(); step();
    #3;
    reset = 1'b0;

    // Read with mem_valid three cycles after the strobe
    do_txn(1, 0, 0, 0, 20'h00010, 20'h0, 32'h0, 32'h0, 3, 32'hDEADBEEF, 0);
    // Secondary write
    do_txn(0, 1, 0, 1, 20'h0, 20'h00100, 32'h0, 32'hCAFEF00D, 2, 32'h12345678, 0);
    // Simultaneous requests, two transactions back to back
    do_txn(1, 1, 0, 0, 20'h00aaa, 20'h00bbb, 32'h0, 32'h0, 1, 32'h11111111, 0);
    do_txn(1, 1, 0, 0, 20'h00aaa, 20'h00bbb, 32'h0, 32'h0, 1, 32'h22222222, 0);

    // Stall and mem_ready gating
    step();
    req0 = 1'b0; req1 = 1'b0; mem_valid = 1'b0;
    stall = 1'b1; req0 = 1'b1; wr0 = 1'b0; addr0 = 20'h00042;
    #3;
    chk("stall_gnt", {gnt0, gnt1}, 2'b00);
    step();
    req0 = 1'b0;
    #3;
    chk("dropped_gnt", {gnt0, gnt1}, 2'b00);
    step();
    req0 = 1'b1; stall = 1'b0; mem_ready = 1'b0;
    #3;
    chk("notready_gnt", {gnt0, gnt1}, 2'b00);
    do_txn(1, 0, 0, 0, 20'h00042, 20'h0, 32'h0, 32'h0, 2, 32'h0BADF00D, 0);

    // Randomized traffic with ignored mem_valid and stall noise
    for (int unsigned n = 0; n < 40; n++) begin
      int unsigned pat;
      pat = $urandom_range(1, 3);
      do_txn(pat[0], pat[1], 1'($urandom), 1'($urandom),
             AW'($urandom), AW'($urandom), $urandom, $urandom,
             $urandom_range(1, 5), $urandom, 1);
    end

    // Reset in WAIT discards the transaction
    step();
    req0 = 1'b1; req1 = 1'b0; wr0 = 1'b0; addr0 = 20'h00777;
    stall = 1'b0; mem_ready = 1'b1; mem_valid = 1'b0;
    #3;
    chk("rw_gnt0", gnt0, 1'b1);
    step();
    req0 = 1'b0;
    #3;
    chk("rw_read", mem_read, 1'b1);
    step();
    #1;
    reset = 1'b1; req0 = 1'b1; mem_valid = 1'b1; mem_out_data = 32'hFFFFFFFF;
    #1;
    chk("rw_flags", {gnt0, gnt1, done0, done1, mem_read, mem_write}, 6'd0);
    chk("rw_addr", mem_address, '0);
    chk("rw_rdata", rdata, '0);
    step();
    #3;
    chk("rw_nodone", {done0, done1, gnt0}, 3'd0);
    req0 = 1'b0; mem_valid = 1'b0; reset = 1'b0;
    last_win = 1'b1;
    do_txn(1, 0, 0, 0, 20'h00321, 20'h0, 32'h0, 32'h0, 1, 32'hA5A5A5A5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
